// File: rtl/mod_exp_ctrl_pkg.sv
// Shared types and constants for the Montgomery-domain modular exponentiation controller.
package mod_exp_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Minimum number of cycles from a multiplier mm_end to the next mm_start.
  localparam int MM_GAP = 2;
  localparam int GAP_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BM,
    ST_XM,
    ST_SQ,
    ST_MUL,
    ST_OUT,
    ST_DONE
  } state_t;

  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } phase_t;

endpackage

// File: rtl/mod_exp_ctrl_idx.sv
// Exponent bit-index counter: loaded with len-1, stepped down once per scanned bit.
module mod_exp_ctrl_idx #(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [IDX_W-1:0] load_val,
  input  logic             dec,
  output logic [IDX_W-1:0] idx,
  output logic             zero
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx <= '0;
    end else if (load) begin
      idx <= load_val;
    end else if (dec) begin
      idx <= idx - IDX_W'(1);
    end
  end

  assign zero = (idx == '0);

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply controller driving an external Montgomery multiplier.
// Every exponent bit below len is scanned, so the squaring count is fixed for a given len.
module mod_exp_ctrl
  import mod_exp_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [7:0]       len,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] r2_mod,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mm_start,
  output logic [7:0]       mm_len,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_n,
  input  logic             mm_end,
  input  logic [WIDTH-1:0] mm_result
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  // mm_start is registered and the WAIT->ISSUE step costs a cycle, which together cover two cycles of gap.
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MM_GAP - 2);

  state_t state, state_next;
  phase_t phase, phase_next;
  logic [GAP_W-1:0] gap, gap_next;

  logic [WIDTH-1:0] base_q, exp_q, r2_q;
  logic [WIDTH-1:0] bm, x;
  logic [WIDTH-1:0] op_a, op_b;

  logic accept, fire, capture;
  logic idx_load, idx_dec, idx_zero;
  logic [IDX_W-1:0] idx;

  mod_exp_ctrl_idx #(
    .IDX_W(IDX_W)
  ) u_idx (
    .clk     (clk),
    .rstn    (rstn),
    .load    (idx_load),
    .load_val(IDX_W'(mm_len - 8'd1)),
    .dec     (idx_dec),
    .idx     (idx),
    .zero    (idx_zero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      phase <= PH_ISSUE;
      gap   <= '0;
    end else begin
      state <= state_next;
      phase <= phase_next;
      gap   <= gap_next;
    end
  end

  always_comb begin
    state_next = state;
    phase_next = phase;
    gap_next   = gap;
    accept     = 1'b0;
    fire       = 1'b0;
    capture    = 1'b0;
    idx_load   = 1'b0;
    idx_dec    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_BM;
          phase_next = PH_ISSUE;
          gap_next   = '0;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        if (phase == PH_ISSUE) begin
          if (gap != '0) begin
            gap_next = gap - GAP_W'(1);
          end else begin
            fire       = 1'b1;
            phase_next = PH_WAIT;
          end
        end else if (mm_end) begin
          capture    = 1'b1;
          phase_next = PH_ISSUE;
          gap_next   = GAP_RELOAD;
          // SQ and MUL fold in the zero-cycle NEXT decision.
          case (state)
            ST_BM:  state_next = ST_XM;
            ST_XM: begin
              state_next = ST_SQ;
              idx_load   = 1'b1;
            end
            ST_SQ: begin
              if (exp_q[idx]) begin
                state_next = ST_MUL;
              end else if (idx_zero) begin
                state_next = ST_OUT;
              end else begin
                idx_dec    = 1'b1;
                state_next = ST_SQ;
              end
            end
            ST_MUL: begin
              if (idx_zero) begin
                state_next = ST_OUT;
              end else begin
                idx_dec    = 1'b1;
                state_next = ST_SQ;
              end
            end
            ST_OUT:  state_next = ST_DONE;
            default: state_next = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      ST_BM: begin
        op_a = base_q;
        op_b = r2_q;
      end
      ST_XM: begin
        op_a = ONE;
        op_b = r2_q;
      end
      ST_SQ: begin
        op_a = x;
        op_b = x;
      end
      ST_MUL: begin
        op_a = x;
        op_b = bm;
      end
      ST_OUT: begin
        op_a = x;
        op_b = ONE;
      end
      default: begin
        op_a = '0;
        op_b = '0;
      end
    endcase
  end

  // Operands are registered on issue so they stay frozen until the product returns.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mm_start <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
      mm_n     <= '0;
      mm_len   <= '0;
      base_q   <= '0;
      exp_q    <= '0;
      r2_q     <= '0;
      bm       <= '0;
      x        <= '0;
      result   <= '0;
    end else begin
      mm_start <= fire;
      if (accept) begin
        mm_len <= len;
        mm_n   <= modulus;
        base_q <= base;
        exp_q  <= exponent;
        r2_q   <= r2_mod;
      end
      if (fire) begin
        mm_a <= op_a;
        mm_b <= op_b;
      end
      if (capture) begin
        case (state)
          ST_BM:   bm     <= mm_result;
          ST_OUT:  result <= mm_result;
          default: x      <= mm_result;
        endcase
      end
    end
  end

  assign busy = (state != ST_IDLE) && (state != ST_DONE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Scoreboard bench for mod_exp_ctrl with a behavioural Montgomery multiplier on the mm_* ports.
module tb_mod_exp_ctrl;

  localparam int MM_LAT = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [7:0]  len;
  logic [31:0] base, exponent, modulus, r2_mod;
  logic        busy, done;
  logic [31:0] result;
  logic        mm_start;
  logic [7:0]  mm_len;
  logic [31:0] mm_a, mm_b, mm_n;
  logic        mm_end_m, spur_end, mm_end_w;
  logic [31:0] mm_result;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          mm;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  int op_mm = 0;
  int cyc = 0;
  int last_end = -100;
  bit stable_bad = 1'b0;
  bit done_prev = 1'b0;

  always #5 clk = ~clk;

  assign mm_end_w = mm_end_m | spur_end;

  mod_exp_ctrl #(.WIDTH(32)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .len      (len),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .r2_mod   (r2_mod),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .mm_start (mm_start),
    .mm_len   (mm_len),
    .mm_a     (mm_a),
    .mm_b     (mm_b),
    .mm_n     (mm_n),
    .mm_end   (mm_end_w),
    .mm_result(mm_result)
  );

  // Behavioural Montgomery product a*b*2^-l mod n.
  function automatic logic [31:0] mont(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] n, input logic [7:0] l);
    logic [63:0] p;
    p = ({32'd0, a} * {32'd0, b}) % {32'd0, n};
    for (int i = 0; i < int'(l); i++) begin
      if (p[0]) p = p + {32'd0, n};
      p = p >> 1;
    end
    return p[31:0];
  endfunction

  logic        m_busy;
  int          m_cnt;
  logic [31:0] la, lb, ln;
  logic [7:0]  ll;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy    <= 1'b0;
      m_cnt     <= 0;
      mm_end_m  <= 1'b0;
      mm_result <= '0;
      la        <= '0;
      lb        <= '0;
      ln        <= '0;
      ll        <= '0;
    end else begin
      mm_end_m <= 1'b0;
      if (mm_start && !m_busy) begin
        la     <= mm_a;
        lb     <= mm_b;
        ln     <= mm_n;
        ll     <= mm_len;
        m_busy <= 1'b1;
        m_cnt  <= MM_LAT;
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          mm_end_m  <= 1'b1;
          mm_result <= mont(la, lb, ln, ll);
          m_busy    <= 1'b0;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic applyStimulus(input string nm, input logic [7:0] l, input logic [31:0] b,
                               input logic [31:0] e, input logic [31:0] n, input logic [31:0] r2,
                               input logic [31:0] exp_res, input int exp_mm, input bit push);
    exp_t item;
    @(negedge clk);
    len = l; base = b; exponent = e; modulus = n; r2_mod = r2;
    start = 1'b1;
    if (push) begin
      item.name = nm;
      item.res  = exp_res;
      item.mm   = exp_mm;
      sb.push_back(item);
    end
    $display("[TB] issue %s", nm);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle(input string nm, input int budget);
    int k;
    k = 0;
    while ((busy || sb.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy || sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_timeout: busy=%0b pending=%0d after %0d cycles", nm, busy, sb.size(), k);
      sb.delete();
    end
  endtask

  task automatic checkAllZero(input string nm);
    checkOutput({nm, "_busy"}, busy, 0);
    checkOutput({nm, "_done"}, done, 0);
    checkOutput({nm, "_result"}, result, 0);
    checkOutput({nm, "_mm_start"}, mm_start, 0);
    checkOutput({nm, "_mm_a"}, mm_a, 0);
    checkOutput({nm, "_mm_b"}, mm_b, 0);
    checkOutput({nm, "_mm_n"}, mm_n, 0);
    checkOutput({nm, "_mm_len"}, mm_len, 0);
  endtask

  // Monitor: gap and operand-stability checks, scoreboard pop on every done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        op_mm      = 0;
        stable_bad = 1'b0;
        done_prev  = 1'b0;
      end else begin
        if (mm_start) begin
          op_mm++;
          compared++;
          if (cyc - last_end < 2) begin
            mismatched++;
            $display("[TB] FAIL mm_gap: got %0d cycles expected at least 2", cyc - last_end);
          end
        end
        if (m_busy || mm_end_m) begin
          if (mm_a !== la || mm_b !== lb || mm_n !== ln || mm_len !== ll) stable_bad = 1'b1;
        end
        if (mm_end_m) begin
          checkOutput("operand_stable", stable_bad, 0);
          stable_bad = 1'b0;
        end
        if (mm_end_w) last_end = cyc;
        if (done) begin
          checkOutput("done_pulse_width", done_prev, 0);
          checkOutput("busy_at_done", busy, 0);
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_done: result=%0h with empty scoreboard", result);
          end else begin
            e = sb.pop_front();
            checkOutput({e.name, "_result"}, result, e.res);
            checkOutput({e.name, "_mm_count"}, op_mm, e.mm);
          end
          op_mm = 0;
        end
        done_prev = done;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    rstn = 1'b0;
    start = 1'b0; len = '0; base = '0; exponent = '0; modulus = '0; r2_mod = '0;
    spur_end = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    spur_end = 1'b1;
    @(negedge clk);
    spur_end = 1'b0;
    checkOutput("spurious_end_busy", busy, 0);
    checkOutput("spurious_end_mm_start", mm_start, 0);
    @(negedge clk);
    checkOutput("spurious_end_done", done, 0);
    repeat (3) @(negedge clk);

    applyStimulus("n13_b2_e5", 8'd4, 32'd2, 32'd5, 32'd13, 32'd9, 32'd6, 9, 1'b1);
    waitIdle("n13_b2_e5", 300);

    applyStimulus("n61_b7_e10", 8'd6, 32'd7, 32'd10, 32'd61, 32'd9, 32'd48, 11, 1'b1);
    repeat (20) @(negedge clk);
    len = 8'd4; base = 32'd3; exponent = 32'd15; modulus = 32'd13; r2_mod = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle("n61_b7_e10", 400);

    applyStimulus("n13_b5_e0", 8'd4, 32'd5, 32'd0, 32'd13, 32'd9, 32'd1, 7, 1'b1);
    k = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL done_wait_timeout: no done after %0d cycles", k);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_in_done_ignored", busy, 0);
    @(negedge clk);
    checkOutput("start_in_done_still_idle", busy, 0);
    waitIdle("n13_b5_e0", 50);

    applyStimulus("n13_b0_e3", 8'd4, 32'd0, 32'd3, 32'd13, 32'd9, 32'd0, 9, 1'b1);
    waitIdle("n13_b0_e3", 300);

    applyStimulus("n61_b60_e63", 8'd6, 32'd60, 32'd63, 32'd61, 32'd9, 32'd60, 15, 1'b1);
    waitIdle("n61_b60_e63", 400);

    applyStimulus("n61_b7_e1", 8'd6, 32'd7, 32'd1, 32'd61, 32'd9, 32'd7, 10, 1'b1);
    waitIdle("n61_b7_e1", 400);

    applyStimulus("abort", 8'd4, 32'd2, 32'd5, 32'd13, 32'd9, 32'd0, 0, 1'b0);
    k = 0;
    while (op_mm < 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (op_mm < 3) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL abort_wait_timeout: only %0d multiplies after %0d cycles", op_mm, k);
    end
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checkAllZero("midrun_reset");
    repeat (2) @(negedge clk);
    #2;
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus("after_reset_n61", 8'd6, 32'd7, 32'd10, 32'd61, 32'd9, 32'd48, 11, 1'b1);
    waitIdle("after_reset_n61", 400);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
